uart_dec_sender: RTL

UART_DEC_SENDER -- requirements
Module: uart_dec_sender

---
 rtl/uart_dec_sender.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_dec_sender.sv
// -----------------------------------------------------------------------------
// uart_dec_sender
//
// Prints an unsigned binary value as decimal ASCII text followed by CR LF,
// one byte at a time, through a downstream UART transmitter. The value is
// converted to BCD with a sequential double-dabble (one shift per cycle).
// Leading zeros are suppressed, and a value of zero prints as "0".
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_value     unsigned value to print (WIDTH bits)
//   i_valid     request; accepted when i_valid && o_ready
//   o_ready     high only while idle
//   o_tx_data   ASCII byte presented to the transmitter
//   o_tx_start  one-cycle pulse requesting transmission of o_tx_data
//   i_tx_busy   transmitter busy (rises the cycle after a start)
// -----------------------------------------------------------------------------
module uart_dec_sender #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_start,
   input  logic             i_tx_busy
);

   localparam int BW = 4 * DIGITS;
   localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, CONVERT, LOAD, START, WAIT_HI, WAIT_LO} state_t;
   typedef enum logic [1:0] {SEL_DIGIT, SEL_CR, SEL_LF} sel_t;

   state_t           state, state_nxt;
   sel_t             sel;
   logic [WIDTH-1:0] shift;
   logic [BW-1:0]    bcd, bcd_adj, bcd_nxt;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    ptr, msd;
   logic [3:0]       digit;
   logic [7:0]       next_byte;

   // Add 3 to every nibble >= 5 so the following left shift carries correctly.
   function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      bcd_adj = dabble_adjust(bcd);
      bcd_nxt = BW'({bcd_adj, shift[WIDTH-1]});
   end

   // Most significant non-zero digit of the post-shift BCD value; stays 0 for
   // a zero value so a single "0" is printed.
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_nxt[i*4 +: 4] != 4'd0) msd = PW'(i);
      end
   end

   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (ptr == PW'(i)) digit = bcd[i*4 +: 4];
      end
   end

   always_comb begin
      case (sel)
         SEL_DIGIT: next_byte = {4'h3, digit};
         SEL_CR:    next_byte = 8'h0D;
         default:   next_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      o_tx_start = 1'b0;
      case (state)
         IDLE:    if (i_valid) state_nxt = CONVERT;
         CONVERT: if (cnt == LAST_SHIFT) state_nxt = LOAD;
         LOAD:    state_nxt = START;
         START: begin
            if (!i_tx_busy) begin
               o_tx_start = !i_rst;
               state_nxt  = WAIT_HI;
            end
         end
         WAIT_HI: if (i_tx_busy) state_nxt = WAIT_LO;
         WAIT_LO: if (!i_tx_busy) state_nxt = (sel == SEL_LF) ? IDLE : LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_ready = (state == IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shift     <= '0;
         bcd       <= '0;
         cnt       <= '0;
         ptr       <= '0;
         sel       <= SEL_DIGIT;
         o_tx_data <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  shift <= i_value;
                  bcd   <= '0;
                  cnt   <= '0;
                  sel   <= SEL_DIGIT;
               end
            end
            CONVERT: begin
               bcd   <= bcd_nxt;
               shift <= {shift[WIDTH-2:0], 1'b0};
               cnt   <= cnt + CW'(1);
               if (cnt == LAST_SHIFT) ptr <= msd;
            end
            LOAD: o_tx_data <= next_byte;
            WAIT_LO: begin
               // Advance to the next byte only once the current one is done.
               if (!i_tx_busy) begin
                  if (sel == SEL_DIGIT) begin
                     if (ptr == '0) sel <= SEL_CR;
                     else           ptr <= ptr - PW'(1);
                  end else if (sel == SEL_CR) begin
                     sel <= SEL_LF;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
